cms_sample_aligner: RTL and testbench

CMS_SAMPLE_ALIGNER -- requirements
Module: cms_sample_aligner

---
 rtl/cms_sample_aligner.sv | 216 +++++++++++++++++++++
 tb/tb_cms_sample_aligner.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cms_sample_aligner.sv
// cms_sample_aligner
// Pairs the measured-sample stream (y) with the estimate stream (y_hat) so the
// downstream mean-square stage always sees y[k] next to y_hat[k]. Each stream
// lands in its own DEPTH-entry FIFO, and the FIFOs accept data in every state.
// A frame of N = 1 << i_log2_samples pairs is started with i_start. The frame
// gives one enable cycle (ARM), one initialisation cycle (WAIT), and then
// pops both FIFOs together while both hold data (STREAM).
//
// Ports
//   i_clk, i_arst_n               clock, asynchronous active-low reset
//   i_start, i_log2_samples       frame request and frame length exponent
//   i_y_valid/i_y/o_y_ready       measured-sample push interface
//   i_y_hat_valid/i_y_hat/o_y_hat_ready  estimate push interface
//   o_cms_en                      one-cycle enable to the downstream stage
//   o_valid/o_y/o_y_hat           aligned pair output
//   o_busy, o_frame_done          frame status

module cms_sample_aligner #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_arst_n,
  input  logic        i_start,
  input  logic [2:0]  i_log2_samples,
  input  logic        i_y_valid,
  input  logic [31:0] i_y,
  output logic        o_y_ready,
  input  logic        i_y_hat_valid,
  input  logic [31:0] i_y_hat,
  output logic        o_y_hat_ready,
  output logic        o_cms_en,
  output logic        o_valid,
  output logic [31:0] o_y,
  output logic [31:0] o_y_hat,
  output logic        o_busy,
  output logic        o_frame_done
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_WAIT,
    ST_STREAM,
    ST_DONE
  } state_e;

  // Storage (data only, no reset needed: occupancy guards every read)
  logic [DW-1:0] y_mem  [DEPTH];
  logic [DW-1:0] yh_mem [DEPTH];

  // y FIFO bookkeeping
  logic [AW-1:0] y_wr_ptr_q, y_wr_ptr_d;
  logic [AW-1:0] y_rd_ptr_q, y_rd_ptr_d;
  logic [CW-1:0] y_count_q,  y_count_d;
  logic          y_ready_q,  y_ready_d;

  // y_hat FIFO bookkeeping
  logic [AW-1:0] yh_wr_ptr_q, yh_wr_ptr_d;
  logic [AW-1:0] yh_rd_ptr_q, yh_rd_ptr_d;
  logic [CW-1:0] yh_count_q,  yh_count_d;
  logic          yh_ready_q,  yh_ready_d;

  // Frame control
  state_e        state_q,    state_d;
  logic [PW-1:0] n_q,        n_d;
  logic [PW-1:0] pair_cnt_q, pair_cnt_d;

  // Registered outputs
  logic          valid_q,      valid_d;
  logic [DW-1:0] out_y_q,      out_y_d;
  logic [DW-1:0] out_yh_q,     out_yh_d;
  logic          cms_en_q,     cms_en_d;
  logic          busy_q,       busy_d;
  logic          frame_done_q, frame_done_d;

  // Handshake / pop qualifiers
  logic y_push;
  logic yh_push;
  logic pop;

  // Ready comes from a flop, so a same-cycle pop never opens the FIFO early
  assign y_push  = i_y_valid     & y_ready_q;
  assign yh_push = i_y_hat_valid & yh_ready_q;

  // Pop both streams together only while streaming and both hold data
  assign pop = (state_q == ST_STREAM) &&
               (y_count_q  != '0) &&
               (yh_count_q != '0) &&
               (pair_cnt_q < n_q);

  // FIFO pointer and occupancy update
  always_comb begin
    y_wr_ptr_d  = y_wr_ptr_q;
    y_rd_ptr_d  = y_rd_ptr_q;
    yh_wr_ptr_d = yh_wr_ptr_q;
    yh_rd_ptr_d = yh_rd_ptr_q;

    if (y_push)  y_wr_ptr_d  = y_wr_ptr_q  + AW'(1);
    if (pop)     y_rd_ptr_d  = y_rd_ptr_q  + AW'(1);
    if (yh_push) yh_wr_ptr_d = yh_wr_ptr_q + AW'(1);
    if (pop)     yh_rd_ptr_d = yh_rd_ptr_q + AW'(1);

    // Simultaneous push and pop cancel out
    y_count_d  = y_count_q  + CW'(y_push)  - CW'(pop);
    yh_count_d = yh_count_q + CW'(yh_push) - CW'(pop);

    y_ready_d  = (y_count_d  != CW'(DEPTH));
    yh_ready_d = (yh_count_d != CW'(DEPTH));
  end

  // Frame state machine and registered output values
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    pair_cnt_d   = pair_cnt_q;
    valid_d      = 1'b0;
    out_y_d      = out_y_q;
    out_yh_d     = out_yh_q;

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d    = ST_ARM;
          n_d        = PW'(1) << i_log2_samples;
          pair_cnt_d = '0;
        end
      end
      ST_ARM:  state_d = ST_WAIT;
      ST_WAIT: state_d = ST_STREAM;
      ST_STREAM: begin
        if (pop) begin
          pair_cnt_d = pair_cnt_q + PW'(1);
          if ((pair_cnt_q + PW'(1)) == n_q) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Pair data only moves on a pop; otherwise the last pair holds
    if (pop) begin
      valid_d  = 1'b1;
      out_y_d  = y_mem[y_rd_ptr_q];
      out_yh_d = yh_mem[yh_rd_ptr_q];
    end

    // Status outputs track the state being entered so they align with it
    cms_en_d     = (state_d == ST_ARM);
    busy_d       = (state_d != ST_IDLE);
    frame_done_d = (state_d == ST_DONE);
  end

  // Sample storage writes
  always_ff @(posedge i_clk) begin
    if (y_push)  y_mem[y_wr_ptr_q]   <= i_y;
    if (yh_push) yh_mem[yh_wr_ptr_q] <= i_y_hat;
  end

  // State registers
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      y_wr_ptr_q   <= '0;
      y_rd_ptr_q   <= '0;
      y_count_q    <= '0;
      y_ready_q    <= 1'b1;
      yh_wr_ptr_q  <= '0;
      yh_rd_ptr_q  <= '0;
      yh_count_q   <= '0;
      yh_ready_q   <= 1'b1;
      state_q      <= ST_IDLE;
      n_q          <= '0;
      pair_cnt_q   <= '0;
      valid_q      <= 1'b0;
      out_y_q      <= '0;
      out_yh_q     <= '0;
      cms_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      y_wr_ptr_q   <= y_wr_ptr_d;
      y_rd_ptr_q   <= y_rd_ptr_d;
      y_count_q    <= y_count_d;
      y_ready_q    <= y_ready_d;
      yh_wr_ptr_q  <= yh_wr_ptr_d;
      yh_rd_ptr_q  <= yh_rd_ptr_d;
      yh_count_q   <= yh_count_d;
      yh_ready_q   <= yh_ready_d;
      state_q      <= state_d;
      n_q          <= n_d;
      pair_cnt_q   <= pair_cnt_d;
      valid_q      <= valid_d;
      out_y_q      <= out_y_d;
      out_yh_q     <= out_yh_d;
      cms_en_q     <= cms_en_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign o_y_ready     = y_ready_q;
  assign o_y_hat_ready = yh_ready_q;
  assign o_cms_en      = cms_en_q;
  assign o_valid       = valid_q;
  assign o_y           = out_y_q;
  assign o_y_hat       = out_yh_q;
  assign o_busy        = busy_q;
  assign o_frame_done  = frame_done_q;

endmodule

// File: tb/tb_cms_sample_aligner.sv
// Directed bench for cms_sample_aligner (DEPTH = 4).
module tb_cms_sample_aligner;

  logic        i_clk = 1'b0;
  logic        i_arst_n;
  logic        i_start;
  logic [2:0]  i_log2_samples;
  logic        i_y_valid;
  logic [31:0] i_y;
  logic        o_y_ready;
  logic        i_y_hat_valid;
  logic [31:0] i_y_hat;
  logic        o_y_hat_ready;
  logic        o_cms_en;
  logic        o_valid;
  logic [31:0] o_y;
  logic [31:0] o_y_hat;
  logic        o_busy;
  logic        o_frame_done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Frame capture buffers filled by capture_frame
  logic [31:0] cap_y  [16];
  logic [31:0] cap_yh [16];
  int          cap_n;
  int          cap_done;
  bit          cap_timeout;

  // Held-source model: data stays pending until the DUT accepts it
  bit          pend_y, pend_h;
  logic [31:0] pend_y_data, pend_h_data;

  cms_sample_aligner #(.DEPTH(4)) dut (
    .i_clk         (i_clk),
    .i_arst_n      (i_arst_n),
    .i_start       (i_start),
    .i_log2_samples(i_log2_samples),
    .i_y_valid     (i_y_valid),
    .i_y           (i_y),
    .o_y_ready     (o_y_ready),
    .i_y_hat_valid (i_y_hat_valid),
    .i_y_hat       (i_y_hat),
    .o_y_hat_ready (o_y_hat_ready),
    .o_cms_en      (o_cms_en),
    .o_valid       (o_valid),
    .o_y           (o_y),
    .o_y_hat       (o_y_hat),
    .o_busy        (o_busy),
    .o_frame_done  (o_frame_done)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push_pair(input logic [31:0] yv, input logic [31:0] hv);
    i_y_valid = 1'b1; i_y = yv;
    i_y_hat_valid = 1'b1; i_y_hat = hv;
    tick();
    i_y_valid = 1'b0; i_y_hat_valid = 1'b0;
  endtask

  // Starts a frame and records every emitted pair until o_busy drops
  task automatic capture_frame(input logic [2:0] l2, input int max_cyc);
    logic acc_y, acc_h;
    bit   fin;
    cap_n = 0; cap_done = 0; cap_timeout = 1'b1; fin = 1'b0;
    for (int c = 0; c < max_cyc && !fin; c++) begin
      i_start        = (c == 0);
      i_log2_samples = l2;
      i_y_valid      = pend_y;  i_y     = pend_y_data;
      i_y_hat_valid  = pend_h;  i_y_hat = pend_h_data;
      acc_y = pend_y && o_y_ready;
      acc_h = pend_h && o_y_hat_ready;
      tick();
      if (acc_y) pend_y = 1'b0;
      if (acc_h) pend_h = 1'b0;
      if (o_valid) begin
        if (cap_n < 16) begin
          cap_y[cap_n]  = o_y;
          cap_yh[cap_n] = o_y_hat;
        end
        cap_n++;
      end
      if (o_frame_done) cap_done++;
      if (!o_busy) begin
        fin = 1'b1;
        cap_timeout = 1'b0;
      end
    end
    i_start = 1'b0; i_y_valid = 1'b0; i_y_hat_valid = 1'b0;
  endtask

  task automatic test_reset();
    i_arst_n = 1'b0;
    i_start = 1'b0; i_log2_samples = 3'd0;
    i_y_valid = 1'b0; i_y = '0;
    i_y_hat_valid = 1'b0; i_y_hat = '0;
    pend_y = 1'b0; pend_h = 1'b0; pend_y_data = '0; pend_h_data = '0;
    #22;
    total_cnt++;
    if ({o_valid, o_cms_en, o_busy, o_frame_done, o_y_ready, o_y_hat_ready} !== 6'b000011)
      $display("FAIL reset_ctrl: got %b expected 000011",
               {o_valid, o_cms_en, o_busy, o_frame_done, o_y_ready, o_y_hat_ready});
    else pass_cnt++;
    total_cnt++;
    if ({o_y, o_y_hat} !== 64'd0)
      $display("FAIL reset_data: got %h expected 0", {o_y, o_y_hat});
    else pass_cnt++;
    @(posedge i_clk); #1;
    i_arst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [31:0] ey, eh;
    for (int k = 0; k < 4; k++) push_pair(32'h1000_0000 + 32'(k), 32'h2000_0000 + 32'(k));
    total_cnt++;
    if (o_y_ready !== 1'b0) $display("FAIL basic_full_ready: got %b expected 0", o_y_ready);
    else pass_cnt++;

    i_start = 1'b1; i_log2_samples = 3'd2;
    tick();
    i_start = 1'b0;
    total_cnt++;
    if ({o_cms_en, o_busy, o_valid} !== 3'b110)
      $display("FAIL basic_arm: got cms_en/busy/valid %b expected 110", {o_cms_en, o_busy, o_valid});
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({o_cms_en, o_busy, o_valid} !== 3'b010)
      $display("FAIL basic_wait: got cms_en/busy/valid %b expected 010", {o_cms_en, o_busy, o_valid});
    else pass_cnt++;
    tick();
    total_cnt++;
    if (o_valid !== 1'b0) $display("FAIL basic_stream_entry_valid: got %b expected 0", o_valid);
    else pass_cnt++;

    for (int k = 0; k < 4; k++) begin
      tick();
      ey = 32'h1000_0000 + 32'(k);
      eh = 32'h2000_0000 + 32'(k);
      total_cnt++;
      if ({o_valid, o_y, o_y_hat} !== {1'b1, ey, eh})
        $display("FAIL basic_pair%0d: got valid=%b y=%h yh=%h expected valid=1 y=%h yh=%h",
                 k, o_valid, o_y, o_y_hat, ey, eh);
      else pass_cnt++;
    end
    total_cnt++;
    if ({o_frame_done, o_busy} !== 2'b11)
      $display("FAIL basic_done: got done/busy %b expected 11", {o_frame_done, o_busy});
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({o_frame_done, o_busy, o_valid, o_y_ready} !== 4'b0001)
      $display("FAIL basic_idle: got done/busy/valid/ready %b expected 0001",
               {o_frame_done, o_busy, o_valid, o_y_ready});
    else pass_cnt++;
  endtask

  task automatic test_skew();
    int yi, hi, gap, oi, nd, hi_prev;
    logic acc_y, acc_h;
    bit fin;
    logic [31:0] ey, eh;
    yi = 0; hi = 0; gap = 0; oi = 0; nd = 0; fin = 1'b0;
    i_start = 1'b1; i_log2_samples = 3'd3;
    tick();
    i_start = 1'b0;
    for (int c = 0; c < 200 && !fin; c++) begin
      i_y_valid     = (yi < 8);
      i_y           = 32'hA0A0_0000 + 32'(yi);
      i_y_hat_valid = (hi < 8) && (gap == 0);
      i_y_hat       = 32'h5050_0000 + 32'(hi);
      acc_y = i_y_valid && o_y_ready;
      acc_h = i_y_hat_valid && o_y_hat_ready;
      hi_prev = hi;
      tick();
      if (acc_y) yi++;
      if (acc_h) begin hi++; gap = 3; end
      else if (gap > 0) gap--;
      if (o_valid) begin
        ey = 32'hA0A0_0000 + 32'(oi);
        eh = 32'h5050_0000 + 32'(oi);
        total_cnt++;
        if ({o_y, o_y_hat} !== {ey, eh})
          $display("FAIL skew_pair%0d: got y=%h yh=%h expected y=%h yh=%h", oi, o_y, o_y_hat, ey, eh);
        else pass_cnt++;
        total_cnt++;
        if (oi >= hi_prev)
          $display("FAIL skew_early%0d: got pair index %0d with %0d y_hat accepted, required fewer",
                   oi, oi, hi_prev);
        else pass_cnt++;
        oi++;
      end
      if (o_frame_done) nd++;
      if (!o_busy) fin = 1'b1;
    end
    i_y_valid = 1'b0; i_y_hat_valid = 1'b0;
    total_cnt++;
    if ({fin, 32'(oi), 32'(nd)} !== {1'b1, 32'd8, 32'd1})
      $display("FAIL skew_totals: got finished=%b pairs=%0d done=%0d expected 1/8/1", fin, oi, nd);
    else pass_cnt++;
  endtask

  task automatic test_full();
    for (int k = 0; k < 6; k++) begin
      i_y_valid = 1'b1; i_y = 32'hC000_0000 + 32'(k);
      total_cnt++;
      if (o_y_ready !== (k < 4))
        $display("FAIL full_ready%0d: got %b expected %b", k, o_y_ready, (k < 4));
      else pass_cnt++;
      tick();
    end
    i_y_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i_y_hat_valid = 1'b1; i_y_hat = 32'hD000_0000 + 32'(k);
      tick();
    end
    i_y_hat_valid = 1'b0;
    capture_frame(3'd2, 40);
    total_cnt++;
    if ({cap_timeout, 32'(cap_n), 32'(cap_done)} !== {1'b0, 32'd4, 32'd1})
      $display("FAIL full_frame: got timeout=%b pairs=%0d done=%0d expected 0/4/1",
               cap_timeout, cap_n, cap_done);
    else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      total_cnt++;
      if ({cap_y[k], cap_yh[k]} !== {32'hC000_0000 + 32'(k), 32'hD000_0000 + 32'(k)})
        $display("FAIL full_order%0d: got y=%h yh=%h expected y=%h yh=%h", k, cap_y[k], cap_yh[k],
                 32'hC000_0000 + 32'(k), 32'hD000_0000 + 32'(k));
      else pass_cnt++;
    end
  endtask

  task automatic test_residual();
    for (int k = 0; k < 4; k++) push_pair(32'hE000_0000 + 32'(k), 32'hF000_0000 + 32'(k));
    pend_y = 1'b1; pend_y_data = 32'hE000_0004;
    pend_h = 1'b1; pend_h_data = 32'hF000_0004;
    capture_frame(3'd2, 40);
    total_cnt++;
    if ({cap_timeout, 32'(cap_n), 32'(cap_done), pend_y, pend_h} !== {1'b0, 32'd4, 32'd1, 2'b00})
      $display("FAIL resid_frame1: got timeout=%b pairs=%0d done=%0d pending=%b%b expected 0/4/1/00",
               cap_timeout, cap_n, cap_done, pend_y, pend_h);
    else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      total_cnt++;
      if ({cap_y[k], cap_yh[k]} !== {32'hE000_0000 + 32'(k), 32'hF000_0000 + 32'(k)})
        $display("FAIL resid_pair%0d: got y=%h yh=%h expected y=%h yh=%h", k, cap_y[k], cap_yh[k],
                 32'hE000_0000 + 32'(k), 32'hF000_0000 + 32'(k));
      else pass_cnt++;
    end
    capture_frame(3'd0, 40);
    total_cnt++;
    if ({cap_timeout, 32'(cap_n), cap_y[0], cap_yh[0]} !== {1'b0, 32'd1, 32'hE000_0004, 32'hF000_0004})
      $display("FAIL resid_frame2: got timeout=%b pairs=%0d y=%h yh=%h expected 0/1/e0000004/f0000004",
               cap_timeout, cap_n, cap_y[0], cap_yh[0]);
    else pass_cnt++;
  endtask

  task automatic test_start_reset();
    int nv, nd;
    nv = 0; nd = 0;
    for (int k = 0; k < 4; k++) push_pair(32'h3300_0000 + 32'(k), 32'h4400_0000 + 32'(k));
    i_start = 1'b1; i_log2_samples = 3'd3;
    tick();
    i_start = 1'b0;
    tick();
    tick();
    // Frame of 8 with only 4 pairs buffered; repeated starts must not disturb it
    for (int c = 0; c < 8; c++) begin
      i_start = 1'b1; i_log2_samples = 3'd0;
      tick();
      if (o_valid) nv++;
      if (o_frame_done) nd++;
    end
    i_start = 1'b0;
    total_cnt++;
    if ({32'(nv), 32'(nd), o_busy} !== {32'd4, 32'd0, 1'b1})
      $display("FAIL ignore_start: got pairs=%0d done=%0d busy=%b expected 4/0/1", nv, nd, o_busy);
    else pass_cnt++;
    i_y_valid = 1'b1; i_y = 32'h5555_0000;
    tick();
    i_y = 32'h5555_0001;
    tick();
    i_y_valid = 1'b0;
    #3;
    i_arst_n = 1'b0;
    #1;
    total_cnt++;
    if ({o_valid, o_cms_en, o_busy, o_frame_done, o_y_ready, o_y_hat_ready} !== 6'b000011)
      $display("FAIL async_reset_ctrl: got %b expected 000011",
               {o_valid, o_cms_en, o_busy, o_frame_done, o_y_ready, o_y_hat_ready});
    else pass_cnt++;
    total_cnt++;
    if ({o_y, o_y_hat} !== 64'd0)
      $display("FAIL async_reset_data: got %h expected 0", {o_y, o_y_hat});
    else pass_cnt++;
    tick();
    tick();
    i_arst_n = 1'b1;
    tick();
    push_pair(32'h0000_0077, 32'h0000_0088);
    capture_frame(3'd0, 40);
    total_cnt++;
    if ({cap_timeout, 32'(cap_n), 32'(cap_done), cap_y[0], cap_yh[0]} !==
        {1'b0, 32'd1, 32'd1, 32'h0000_0077, 32'h0000_0088})
      $display("FAIL post_reset_empty: got timeout=%b pairs=%0d done=%0d y=%h yh=%h expected 0/1/1/77/88",
               cap_timeout, cap_n, cap_done, cap_y[0], cap_yh[0]);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_skew();
    test_full();
    test_residual();
    test_start_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
